int64_to_double: RTL and testbench



---
 rtl/int64_to_double_pkg.sv | 33 +++
 rtl/int64_to_double_if.sv | 21 ++
 rtl/int64_to_double.sv | 126 ++++++++++++
 tb/tb_int64_to_double.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/int64_to_double_pkg.sv
// Shared double-precision helpers: FSM encoding, IEEE-754 field widths and the
// round-to-nearest-even decision used by this converter and the add/sub units.
package int64_to_double_pkg;

  typedef enum logic [2:0] {
    GET_A,
    CONVERT_0,
    CONVERT_1,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  localparam int DBL_EXP_BIAS = 1023;
  localparam int DBL_MANT_W   = 52;
  localparam int DBL_EXP_W    = 11;

  localparam logic [63:0] DBL_POS_ZERO = 64'h0;

  typedef struct packed {
    state_t              state;
    logic [7:0]          z_e;
    logic [DBL_MANT_W:0] z_m;
    logic                sign;
  } i2d_dbg_t;

  // Round up when past halfway, or exactly halfway with an odd lsb.
  function automatic logic rne_incr(input logic lsb, input logic guard,
                                    input logic round_bit, input logic sticky);
    return guard & (round_bit | sticky | lsb);
  endfunction

endpackage

// File: rtl/int64_to_double_if.sv
// Operand/result channels of the converter.
// Handshake: a word moves on a rising clk edge where both stb and ack are high;
// the sender holds data stable while stb is high, and ack before stb means nothing.
interface int64_to_double_if;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/int64_to_double.sv
// 64-bit integer to IEEE-754 double: one-bit-per-cycle normalise, then
// round-to-nearest-even. Exact powers and wrap-around carries need no special path.
module int64_to_double
  import int64_to_double_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  int64_to_double_if.slave     io,
  output i2d_dbg_t             dbg
);

  state_t state_q, state_d;

  logic        ack_q, ack_d;
  logic        stb_q, stb_d;
  logic [63:0] z_out_q, z_out_d;

  logic [63:0]         a_q;
  logic [63:0]         value_q;
  logic                sign_q;
  logic [7:0]          z_e_q;
  logic [DBL_MANT_W:0] z_m_q;
  logic [63:0]         z_q;

  logic                 a_neg;
  logic [DBL_MANT_W:0]  mant;
  logic                 guard, round_bit, sticky;
  logic [DBL_EXP_W-1:0] exp_field;

  assign a_neg     = SIGNED_IN & a_q[63];
  assign mant      = value_q[63 -: DBL_MANT_W + 1];
  assign guard     = value_q[62 - DBL_MANT_W];
  assign round_bit = value_q[61 - DBL_MANT_W];
  assign sticky    = |value_q[60 - DBL_MANT_W:0];
  assign exp_field = {{(DBL_EXP_W - 8){1'b0}}, z_e_q} + DBL_EXP_W'(DBL_EXP_BIAS);

  // State register plus the registered handshake outputs.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ack_q   <= ack_d;
    stb_q   <= stb_d;
    z_out_q <= z_out_d;
    if (rst) begin
      state_q <= GET_A;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      z_out_q <= DBL_POS_ZERO;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_A:     if (ack_q && io.input_a_stb) state_d = CONVERT_0;
      CONVERT_0: state_d = (a_q == 64'd0) ? PUT_Z : CONVERT_1;
      CONVERT_1: if (value_q[63]) state_d = ROUND;
      ROUND:     state_d = PACK;
      PACK:      state_d = PUT_Z;
      PUT_Z:     if (stb_q && io.output_z_ack) state_d = GET_A;
      default:   state_d = GET_A;
    endcase
  end

  always_comb begin
    ack_d   = ack_q;
    stb_d   = stb_q;
    z_out_d = z_out_q;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && io.input_a_stb) ack_d = 1'b0;
      end
      PUT_Z: begin
        stb_d   = 1'b1;
        z_out_d = z_q;
        if (stb_q && io.output_z_ack) stb_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath; zero never reaches CONVERT_1, so the normalise loop terminates.
  always_ff @(posedge clk) begin
    case (state_q)
      GET_A: begin
        if (ack_q && io.input_a_stb) a_q <= io.input_a;
      end
      CONVERT_0: begin
        if (a_q == 64'd0) begin
          z_q <= DBL_POS_ZERO;
        end else begin
          sign_q  <= a_neg;
          value_q <= a_neg ? (~a_q + 64'd1) : a_q;
          z_e_q   <= 8'd63;
        end
      end
      CONVERT_1: begin
        if (!value_q[63]) begin
          value_q <= value_q << 1;
          z_e_q   <= z_e_q - 8'd1;
        end
      end
      ROUND: begin
        if (rne_incr(mant[0], guard, round_bit, sticky)) begin
          z_m_q <= mant + 1'b1;
          if (&mant) z_e_q <= z_e_q + 8'd1;
        end else begin
          z_m_q <= mant;
        end
      end
      PACK: begin
        z_q <= {sign_q, exp_field, z_m_q[DBL_MANT_W-1:0]};
      end
      default: ;
    endcase
  end

  assign io.input_a_ack  = ack_q;
  assign io.output_z_stb = stb_q;
  assign io.output_z     = z_out_q;

  assign dbg = '{state: state_q, z_e: z_e_q, z_m: z_m_q, sign: sign_q};

endmodule

// File: tb/tb_int64_to_double.sv
// Directed bench for int64_to_double: signed and unsigned instances, scoreboard
// of expected results and latencies, backpressure and mid-conversion reset.
module tb_int64_to_double;
  import int64_to_double_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int64_to_double_if s_if ();
  int64_to_double_if u_if ();
  i2d_dbg_t dbg_s, dbg_u;

  int64_to_double #(.SIGNED_IN(1'b1)) dut_s (.clk(clk), .rst(rst), .io(s_if), .dbg(dbg_s));
  int64_to_double #(.SIGNED_IN(1'b0)) dut_u (.clk(clk), .rst(rst), .io(u_if), .dbg(dbg_u));

  // Scoreboard: expected word, expected latency and capture cycle per instance
  logic [63:0] exp_q_s[$];
  logic [63:0] exp_q_u[$];
  int          lat_q_s[$], lat_q_u[$];
  int          cap_q_s[$], cap_q_u[$];
  logic        s_prev = 1'b0;
  logic        u_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_out(input bit sel, input logic [63:0] z);
    logic [63:0] ez;
    int el, ec;
    if ((sel ? exp_q_u.size() : exp_q_s.size()) == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_out_%s: got %h, expected no output", sel ? "u" : "s", z);
      return;
    end
    if (sel) begin
      ez = exp_q_u.pop_front(); el = lat_q_u.pop_front(); ec = cap_q_u.pop_front();
    end else begin
      ez = exp_q_s.pop_front(); el = lat_q_s.pop_front(); ec = cap_q_s.pop_front();
    end
    chk(sel ? "result_u" : "result_s", z, ez);
    chk(sel ? "latency_u" : "latency_s", 64'(cyc - ec), 64'(el));
  endtask

  // Monitor: compare on each rising output_z_stb
  always @(negedge clk) begin
    if (!rst && s_if.output_z_stb && !s_prev) check_out(1'b0, s_if.output_z);
    if (!rst && u_if.output_z_stb && !u_prev) check_out(1'b1, u_if.output_z);
    s_prev <= s_if.output_z_stb;
    u_prev <= u_if.output_z_stb;
  end

  // Called at a negedge; returns at the negedge after the capture edge
  task automatic send(input bit sel, input logic [63:0] a, input logic [63:0] ez,
                      input int el, input bit expect_out);
    int n = 0;
    if (sel) begin u_if.input_a = a; u_if.input_a_stb = 1'b1; end
    else     begin s_if.input_a = a; s_if.input_a_stb = 1'b1; end
    while (!(sel ? u_if.input_a_ack : s_if.input_a_ack) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: input_a_ack never high for a=%h", a);
    end else if (expect_out) begin
      if (sel) begin exp_q_u.push_back(ez); lat_q_u.push_back(el); cap_q_u.push_back(cyc + 1); end
      else     begin exp_q_s.push_back(ez); lat_q_s.push_back(el); cap_q_s.push_back(cyc + 1); end
    end
    @(negedge clk);
    u_if.input_a_stb = 1'b0;
    s_if.input_a_stb = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q_s.size() != 0 || exp_q_u.size() != 0 ||
            s_if.output_z_stb || u_if.output_z_stb) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: outputs pending s=%0d u=%0d", exp_q_s.size(), exp_q_u.size());
    end
  endtask

  task automatic conv(input bit sel, input logic [63:0] a, input logic [63:0] ez, input int el);
    send(sel, a, ez, el, 1'b1);
    wait_idle();
  endtask

  initial begin
    int n;
    s_if.input_a = '0; s_if.input_a_stb = 1'b0; s_if.output_z_ack = 1'b1;
    u_if.input_a = '0; u_if.input_a_stb = 1'b0; u_if.output_z_ack = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(s_if.input_a_ack), 64'd0);
    chk("rst_stb", 64'(s_if.output_z_stb), 64'd0);
    chk("rst_z", s_if.output_z, 64'h0);
    chk("rst_state", 64'(dbg_s.state), 64'(GET_A));
    rst = 1'b0;
    @(negedge clk);
    chk("ack_after_rst", 64'(s_if.input_a_ack), 64'd1);

    // Directed conversions: instance, operand, result, stb latency
    conv(0, 64'd1,                  64'h3FF0_0000_0000_0000, 68);
    conv(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBFF0_0000_0000_0000, 68);
    conv(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h43F0_0000_0000_0000, 5);
    conv(0, 64'h8000_0000_0000_0000, 64'hC3E0_0000_0000_0000, 5);
    conv(1, 64'h8000_0000_0000_0000, 64'h43E0_0000_0000_0000, 5);
    conv(0, 64'd0,                  64'h0,                   2);
    conv(1, 64'd0,                  64'h0,                   2);
    conv(0, 64'h0020_0000_0000_0001, 64'h4340_0000_0000_0000, 15);
    conv(0, 64'h0020_0000_0000_0003, 64'h4340_0000_0000_0002, 15);
    conv(1, 64'h0020_0000_0000_0003, 64'h4340_0000_0000_0002, 15);
    conv(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h43E0_0000_0000_0000, 6);
    conv(1, 64'd1,                  64'h3FF0_0000_0000_0000, 68);

    // Output backpressure
    s_if.output_z_ack = 1'b0;
    send(0, 64'd5, 64'h4014_0000_0000_0000, 66, 1'b1);
    n = 0;
    while (!s_if.output_z_stb && n < 100) begin @(negedge clk); n++; end
    chk("bp_stb_seen", 64'(s_if.output_z_stb), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stb_hold", 64'(s_if.output_z_stb), 64'd1);
      chk("bp_z_hold", s_if.output_z, 64'h4014_0000_0000_0000);
      chk("bp_ack_low", 64'(s_if.input_a_ack), 64'd0);
    end
    s_if.output_z_ack = 1'b1;
    @(negedge clk);
    s_if.output_z_ack = 1'b0;
    chk("bp_stb_fall", 64'(s_if.output_z_stb), 64'd0);
    s_if.output_z_ack = 1'b1;
    conv(0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hC000_0000_0000_0000, 67);

    // Reset in the middle of normalisation
    send(0, 64'd1, 64'h0, 0, 1'b0);
    repeat (19) @(negedge clk);
    chk("mid_state", 64'(dbg_s.state), 64'(CONVERT_1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", 64'(s_if.input_a_ack), 64'd0);
    chk("mid_rst_stb", 64'(s_if.output_z_stb), 64'd0);
    chk("mid_rst_z", s_if.output_z, 64'h0);
    chk("mid_rst_state", 64'(dbg_s.state), 64'(GET_A));
    rst = 1'b0;
    @(negedge clk);
    conv(0, 64'd3, 64'h4008_0000_0000_0000, 67);

    repeat (5) @(negedge clk);
    chk("queue_s_empty", 64'(exp_q_s.size()), 64'd0);
    chk("queue_u_empty", 64'(exp_q_u.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
